multicycle_control: RTL and testbench

- Moore FSM that sequences the multicycle MIPS datapath and drives the ALU's `ALUOperation` code.
- Decodes opcode/funct held in the instruction register and produces every datapath enable and mux select.
- Consumes the ALU's `Zero` flag to resolve BEQ/BNE.
- Stalls on a memory ready handshake.

---
 rtl/mips_pkg.sv | 108 ++++++++++
 rtl/multicycle_control_if.sv | 38 +++
 rtl/alu_op_decoder.sv | 47 ++++
 rtl/multicycle_control.sv | 172 +++++++++++++++++
 tb/tb_multicycle_control.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: ALU operation codes,
// opcode/funct constants, datapath select encodings, FSM state enum and the
// registered control word.
package mips_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned ALUOP_W = 4;

    typedef logic [OP_W-1:0]    op_t;
    typedef logic [ALUOP_W-1:0] aluop_t;

    // ALU operation codes (same encoding as the ALU)
    localparam aluop_t ALU_AND  = 4'b0000;
    localparam aluop_t ALU_OR   = 4'b0001;
    localparam aluop_t ALU_NOR  = 4'b0010;
    localparam aluop_t ALU_ADD  = 4'b0011;
    localparam aluop_t ALU_SUB  = 4'b0100;
    localparam aluop_t ALU_SLL  = 4'b0101;
    localparam aluop_t ALU_SRL  = 4'b0110;
    localparam aluop_t ALU_ORI  = 4'b1100;
    localparam aluop_t ALU_LUI  = 4'b1101;
    localparam aluop_t ALU_ADDI = 4'b1110;

    // Opcodes
    localparam op_t OPC_RTYPE = 6'b000000;
    localparam op_t OPC_J     = 6'b000010;
    localparam op_t OPC_BEQ   = 6'b000100;
    localparam op_t OPC_BNE   = 6'b000101;
    localparam op_t OPC_ADDI  = 6'b001000;
    localparam op_t OPC_ORI   = 6'b001101;
    localparam op_t OPC_LUI   = 6'b001111;
    localparam op_t OPC_LW    = 6'b100011;
    localparam op_t OPC_SW    = 6'b101011;

    // R-type funct codes
    localparam op_t FN_SLL = 6'b000000;
    localparam op_t FN_SRL = 6'b000010;
    localparam op_t FN_ADD = 6'b100000;
    localparam op_t FN_SUB = 6'b100010;
    localparam op_t FN_AND = 6'b100100;
    localparam op_t FN_OR  = 6'b100101;
    localparam op_t FN_NOR = 6'b100111;

    // ALUSrcB select
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PCSource select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC_R,
        ST_WB_R,
        ST_EXEC_I,
        ST_WB_I,
        ST_MEM_ADDR,
        ST_MEM_RD,
        ST_WB_MEM,
        ST_MEM_WR,
        ST_BRANCH,
        ST_JUMP,
        ST_ILLEGAL
    } state_t;

    // Which rule selects the ALU code in a given state
    typedef enum logic [1:0] {
        ALU_CLS_ADD,
        ALU_CLS_R,
        ALU_CLS_I,
        ALU_CLS_SUB
    } alu_class_t;

    // Registered control word; fetch/jump/branch/bne qualify PCEn and IRWrite
    typedef struct packed {
        aluop_t     alu_op;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       illegal;
        logic       fetch;
        logic       jump;
        logic       branch;
        logic       bne;
    } ctrl_t;

    // Quiescent control word: every enable low, selects zero, ALU on ADD
    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c        = '0;
        c.alu_op = ALU_ADD;
        c.src_b  = SRCB_B;
        c.pc_src = PCSRC_ALU;
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath signal bundle.
//   master : controller side (decode/flag inputs in, enables/selects out)
//   slave  : datapath side
interface multicycle_control_if;
    import mips_pkg::*;

    op_t        Opcode;
    op_t        Funct;
    logic       Zero;
    logic       MemReady;
    aluop_t     ALUOperation;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic       PCEn;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       IllegalInstr;

    modport master (
        input  Opcode, Funct, Zero, MemReady,
        output ALUOperation, ALUSrcA, ALUSrcB, PCSource, PCEn, IorD,
               MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               IllegalInstr
    );

    modport slave (
        output Opcode, Funct, Zero, MemReady,
        input  ALUOperation, ALUSrcA, ALUSrcB, PCSource, PCEn, IorD,
               MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               IllegalInstr
    );
endinterface

// File: rtl/alu_op_decoder.sv
// Maps (state class, Opcode, Funct) to the ALU operation code and flags an
// undefined funct (R class) or non-ALU opcode (I class).
//   alu_class : which decode rule applies
//   opcode    : IR[31:26]
//   funct     : IR[5:0]
//   alu_op    : ALU operation code
//   illegal   : no valid mapping for this class
module alu_op_decoder
    import mips_pkg::*;
(
    input  alu_class_t alu_class,
    input  op_t        opcode,
    input  op_t        funct,
    output aluop_t     alu_op,
    output logic       illegal
);

    always_comb begin
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        case (alu_class)
            ALU_CLS_R: begin
                case (funct)
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_SLL:  alu_op = ALU_SLL;
                    FN_SRL:  alu_op = ALU_SRL;
                    default: illegal = 1'b1;
                endcase
            end
            ALU_CLS_I: begin
                case (opcode)
                    OPC_ADDI: alu_op = ALU_ADDI;
                    OPC_ORI:  alu_op = ALU_ORI;
                    OPC_LUI:  alu_op = ALU_LUI;
                    default:  illegal = 1'b1;
                endcase
            end
            ALU_CLS_SUB: alu_op = ALU_SUB;
            default:     alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore controller for the multicycle MIPS datapath.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   ctl   : controller side of multicycle_control_if (Opcode/Funct/Zero/
//           MemReady in; ALUOperation, selects and enables out)
// Outputs are registered from the next state. Only IRWrite/PCEn combine a
// registered qualifier with MemReady (FETCH) or Zero (BRANCH).
// Build option ILLEGAL_TRAP_EN: ILLEGAL becomes terminal until reset.
module multicycle_control
    import mips_pkg::*;
(
    input logic                  clk,
    input logic                  reset,
    multicycle_control_if.master ctl
);

    state_t     state_q, state_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic       funct_bad_q, funct_bad_d;
    logic       mem_load_q, mem_load_d;
    alu_class_t cls_d;
    aluop_t     dec_op;
    logic       dec_illegal;

    alu_op_decoder u_alu_op_decoder (
        .alu_class (cls_d),
        .opcode    (ctl.Opcode),
        .funct     (ctl.Funct),
        .alu_op    (dec_op),
        .illegal   (dec_illegal)
    );

    // Next state. FETCH only completes once the read request is actually out,
    // so the first cycle after reset release never skips the fetch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:    if (ctrl_q.fetch && ctl.MemReady) state_d = ST_DECODE;
            ST_DECODE: begin
                case (ctl.Opcode)
                    OPC_RTYPE:                 state_d = ST_EXEC_R;
                    OPC_LW, OPC_SW:            state_d = ST_MEM_ADDR;
                    OPC_ADDI, OPC_ORI, OPC_LUI: state_d = ST_EXEC_I;
                    OPC_BEQ, OPC_BNE:          state_d = ST_BRANCH;
                    OPC_J:                     state_d = ST_JUMP;
                    default:                   state_d = ST_ILLEGAL;
                endcase
            end
            ST_EXEC_R:   state_d = funct_bad_q ? ST_ILLEGAL : ST_WB_R;
            ST_WB_R:     state_d = ST_FETCH;
            ST_EXEC_I:   state_d = ST_WB_I;
            ST_WB_I:     state_d = ST_FETCH;
            ST_MEM_ADDR: state_d = mem_load_q ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   if (ctl.MemReady) state_d = ST_WB_MEM;
            ST_WB_MEM:   state_d = ST_FETCH;
            ST_MEM_WR:   if (ctl.MemReady) state_d = ST_FETCH;
            ST_BRANCH:   state_d = ST_FETCH;
            ST_JUMP:     state_d = ST_FETCH;
`ifdef ILLEGAL_TRAP_EN
            ST_ILLEGAL:  state_d = ST_ILLEGAL;
`else
            ST_ILLEGAL:  state_d = ST_FETCH;
`endif
            default:     state_d = ST_FETCH;
        endcase
    end

    // ALU decode rule for the state being entered
    always_comb begin
        cls_d = ALU_CLS_ADD;
        case (state_d)
            ST_EXEC_R: cls_d = ALU_CLS_R;
            ST_EXEC_I: cls_d = ALU_CLS_I;
            ST_BRANCH: cls_d = ALU_CLS_SUB;
            default:   cls_d = ALU_CLS_ADD;
        endcase
    end

    // Control word for the state being entered; IR fields are sampled here
    // while leaving DECODE (the IR is stable from then on)
    always_comb begin
        ctrl_d        = ctrl_idle();
        ctrl_d.alu_op = dec_op;
        funct_bad_d   = funct_bad_q;
        mem_load_d    = mem_load_q;
        case (state_d)
            ST_FETCH: begin
                ctrl_d.mem_read = 1'b1;
                ctrl_d.src_b    = SRCB_FOUR;
                ctrl_d.fetch    = 1'b1;
            end
            ST_DECODE:   ctrl_d.src_b = SRCB_IMM_SH;
            ST_EXEC_R: begin
                ctrl_d.src_a = 1'b1;
                ctrl_d.src_b = SRCB_B;
                funct_bad_d  = dec_illegal;
            end
            ST_WB_R: begin
                ctrl_d.reg_dst   = 1'b1;
                ctrl_d.reg_write = 1'b1;
            end
            ST_EXEC_I: begin
                ctrl_d.src_a = 1'b1;
                ctrl_d.src_b = SRCB_IMM;
            end
            ST_WB_I:     ctrl_d.reg_write = 1'b1;
            ST_MEM_ADDR: begin
                ctrl_d.src_a = 1'b1;
                ctrl_d.src_b = SRCB_IMM;
                mem_load_d   = (ctl.Opcode == OPC_LW);
            end
            ST_MEM_RD: begin
                ctrl_d.iord     = 1'b1;
                ctrl_d.mem_read = 1'b1;
            end
            ST_WB_MEM: begin
                ctrl_d.mem_to_reg = 1'b1;
                ctrl_d.reg_write  = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl_d.iord      = 1'b1;
                ctrl_d.mem_write = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_d.src_a  = 1'b1;
                ctrl_d.src_b  = SRCB_B;
                ctrl_d.pc_src = PCSRC_ALUOUT;
                ctrl_d.branch = 1'b1;
                ctrl_d.bne    = (ctl.Opcode == OPC_BNE);
            end
            ST_JUMP: begin
                ctrl_d.pc_src = PCSRC_JUMP;
                ctrl_d.jump   = 1'b1;
            end
            ST_ILLEGAL:  ctrl_d.illegal = 1'b1;
            default:     ctrl_d = ctrl_idle();
        endcase
    end

    // State and control-word registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_FETCH;
            ctrl_q      <= ctrl_idle();
            funct_bad_q <= 1'b0;
            mem_load_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            funct_bad_q <= funct_bad_d;
            mem_load_q  <= mem_load_d;
        end
    end

    assign ctl.ALUOperation = ctrl_q.alu_op;
    assign ctl.ALUSrcA      = ctrl_q.src_a;
    assign ctl.ALUSrcB      = ctrl_q.src_b;
    assign ctl.PCSource     = ctrl_q.pc_src;
    assign ctl.IorD         = ctrl_q.iord;
    assign ctl.MemRead      = ctrl_q.mem_read;
    assign ctl.MemWrite     = ctrl_q.mem_write;
    assign ctl.RegDst       = ctrl_q.reg_dst;
    assign ctl.MemtoReg     = ctrl_q.mem_to_reg;
    assign ctl.RegWrite     = ctrl_q.reg_write;
    assign ctl.IllegalInstr = ctrl_q.illegal;

    // IR load and PC update: fetch completes on MemReady, branch resolves on Zero
    assign ctl.IRWrite = ctrl_q.fetch & ctl.MemReady;
    assign ctl.PCEn    = (ctrl_q.fetch & ctl.MemReady) | ctrl_q.jump
                       | (ctrl_q.branch & (ctl.Zero ^ ctrl_q.bne));

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control. Each instruction is expanded into
// the per-cycle phase sequence it must follow, and each phase into the
// output values that must be visible in that cycle.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    multicycle_control_if ctl ();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .ctl   (ctl)
    );

    typedef enum int {
        P_FETCH, P_DECODE, P_EXR, P_WBR, P_EXI, P_WBI, P_ADDR,
        P_MRD, P_WBM, P_MWR, P_BR, P_J, P_ILL
    } phase_e;

    typedef struct {
        phase_e ph;
        logic   mr;
        logic   z;
    } step_t;

    typedef struct packed {
        logic [3:0] alu;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic       pcen;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       irw;
        logic       rdst;
        logic       m2r;
        logic       rw;
        logic       ill;
    } sig_t;

    step_t      trace[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc    = 0;
    logic [5:0] cur_op;
    logic [5:0] cur_fn;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] r_alu(input logic [5:0] fn, output logic ok);
        ok = 1'b1;
        case (fn)
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b100111: return 4'b0010;
            6'b100000: return 4'b0011;
            6'b100010: return 4'b0100;
            6'b000000: return 4'b0101;
            6'b000010: return 4'b0110;
            default: begin
                ok = 1'b0;
                return 4'b0000;
            end
        endcase
    endfunction

    function automatic logic [3:0] i_alu(input logic [5:0] op);
        case (op)
            6'b001000: return 4'b1110;
            6'b001101: return 4'b1100;
            default:   return 4'b1101;
        endcase
    endfunction

    function automatic sig_t observe();
        sig_t o;
        o.alu   = ctl.ALUOperation;
        o.srca  = ctl.ALUSrcA;
        o.srcb  = ctl.ALUSrcB;
        o.pcsrc = ctl.PCSource;
        o.pcen  = ctl.PCEn;
        o.iord  = ctl.IorD;
        o.mr    = ctl.MemRead;
        o.mw    = ctl.MemWrite;
        o.irw   = ctl.IRWrite;
        o.rdst  = ctl.RegDst;
        o.m2r   = ctl.MemtoReg;
        o.rw    = ctl.RegWrite;
        o.ill   = ctl.IllegalInstr;
        return o;
    endfunction

    // Required outputs for one cycle; m marks fields the phase defines
    task automatic expect_step(input step_t s, output sig_t v, output sig_t m);
        logic ok;
        v = '0;
        m = '0;
        m.pcen = 1'b1; m.mr = 1'b1; m.mw = 1'b1; m.irw = 1'b1; m.rw = 1'b1; m.ill = 1'b1;
        case (s.ph)
            P_FETCH: begin
                v.mr = 1'b1; m.iord = 1'b1; m.srca = 1'b1;
                v.srcb = 2'b01; m.srcb = 2'b11; v.alu = 4'b0011; m.alu = 4'hF;
                m.pcsrc = 2'b11; v.irw = s.mr; v.pcen = s.mr;
            end
            P_DECODE: begin
                m.srca = 1'b1; v.srcb = 2'b11; m.srcb = 2'b11; v.alu = 4'b0011; m.alu = 4'hF;
            end
            P_EXR: begin
                v.srca = 1'b1; m.srca = 1'b1; m.srcb = 2'b11;
                v.alu = r_alu(cur_fn, ok);
                if (ok) m.alu = 4'hF;
            end
            P_WBR: begin
                v.rdst = 1'b1; m.rdst = 1'b1; m.m2r = 1'b1; v.rw = 1'b1;
            end
            P_EXI: begin
                v.srca = 1'b1; m.srca = 1'b1; v.srcb = 2'b10; m.srcb = 2'b11;
                v.alu = i_alu(cur_op); m.alu = 4'hF;
            end
            P_WBI: begin
                m.rdst = 1'b1; m.m2r = 1'b1; v.rw = 1'b1;
            end
            P_ADDR: begin
                v.srca = 1'b1; m.srca = 1'b1; v.srcb = 2'b10; m.srcb = 2'b11;
                v.alu = 4'b0011; m.alu = 4'hF;
            end
            P_MRD: begin
                v.iord = 1'b1; m.iord = 1'b1; v.mr = 1'b1;
            end
            P_WBM: begin
                m.rdst = 1'b1; v.m2r = 1'b1; m.m2r = 1'b1; v.rw = 1'b1;
            end
            P_MWR: begin
                v.iord = 1'b1; m.iord = 1'b1; v.mw = 1'b1;
            end
            P_BR: begin
                v.srca = 1'b1; m.srca = 1'b1; m.srcb = 2'b11;
                v.alu = 4'b0100; m.alu = 4'hF; v.pcsrc = 2'b01; m.pcsrc = 2'b11;
                v.pcen = (cur_op == 6'b000100) ? s.z : ~s.z;
            end
            P_J: begin
                v.pcsrc = 2'b10; m.pcsrc = 2'b11; v.pcen = 1'b1;
            end
            default: v.ill = 1'b1;
        endcase
    endtask

    function automatic step_t mk(input phase_e p, input logic mr, input int zf);
        step_t s;
        s.ph = p;
        s.mr = mr;
        s.z  = (zf < 0) ? 1'($urandom_range(0, 1)) : 1'(zf);
        return s;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Phase sequence an instruction must take through the controller
    task automatic build(input logic [5:0] op, input logic [5:0] fn,
                         input int fstall, input int mstall, input int zf);
        logic ok;
        trace.delete();
        repeat (fstall) trace.push_back(mk(P_FETCH, 1'b0, zf));
        trace.push_back(mk(P_FETCH, 1'b1, zf));
        trace.push_back(mk(P_DECODE, rbit(), zf));
        case (op)
            6'b000000: begin
                void'(r_alu(fn, ok));
                trace.push_back(mk(P_EXR, rbit(), zf));
                trace.push_back(mk(ok ? P_WBR : P_ILL, rbit(), zf));
            end
            6'b100011: begin
                trace.push_back(mk(P_ADDR, rbit(), zf));
                repeat (mstall) trace.push_back(mk(P_MRD, 1'b0, zf));
                trace.push_back(mk(P_MRD, 1'b1, zf));
                trace.push_back(mk(P_WBM, rbit(), zf));
            end
            6'b101011: begin
                trace.push_back(mk(P_ADDR, rbit(), zf));
                repeat (mstall) trace.push_back(mk(P_MWR, 1'b0, zf));
                trace.push_back(mk(P_MWR, 1'b1, zf));
            end
            6'b001000, 6'b001101, 6'b001111: begin
                trace.push_back(mk(P_EXI, rbit(), zf));
                trace.push_back(mk(P_WBI, rbit(), zf));
            end
            6'b000100, 6'b000101: trace.push_back(mk(P_BR, rbit(), zf));
            6'b000010:            trace.push_back(mk(P_J, rbit(), zf));
            default:              trace.push_back(mk(P_ILL, rbit(), zf));
        endcase
    endtask

    // Drive and check the first n steps of the trace, one per clock
    task automatic run_trace(input int n);
        sig_t v, m, o;
        logic [17:0] ov, vv, mv;
        phase_e p;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ctl.MemReady = trace[i].mr;
            ctl.Zero     = trace[i].z;
            if (trace[i].ph == P_FETCH) begin
                ctl.Opcode = 6'($urandom);
                ctl.Funct  = 6'($urandom);
            end else begin
                ctl.Opcode = cur_op;
                ctl.Funct  = cur_fn;
            end
            #1;
            expect_step(trace[i], v, m);
            o  = observe();
            ov = o; vv = v; mv = m;
            p  = trace[i].ph;
            check_val($sformatf("%s_op%b_c%0d", p.name(), cur_op, cyc), 32'(ov & mv), 32'(vv & mv));
            cyc++;
        end
    endtask

    task automatic do_reset();
        sig_t rv, o;
        logic [17:0] ov, rvv;
        rv     = '0;
        rv.alu = 4'b0011;
        rvv    = rv;
        @(negedge clk);
        #2 reset = 1'b0;
        #1 o = observe(); ov = o;
        check_val("reset_async", 32'(ov), 32'(rvv));
        @(posedge clk);
        #1 o = observe(); ov = o;
        check_val("reset_hold", 32'(ov), 32'(rvv));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fstall, input int mstall, input int zf);
        cur_op = op;
        cur_fn = fn;
        build(op, fn, fstall, mstall, zf);
        run_trace(trace.size());
`ifdef ILLEGAL_TRAP_EN
        if (trace[trace.size()-1].ph == P_ILL) begin
            trace.delete();
            repeat (20) trace.push_back(mk(P_ILL, rbit(), -1));
            run_trace(20);
            do_reset();
        end
`endif
    endtask

    logic [5:0] op_pool [9] = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b001101,
                                6'b001111, 6'b000100, 6'b000101, 6'b000010};
    logic [5:0] fn_pool [7] = '{6'b100100, 6'b100101, 6'b100111, 6'b100000,
                                6'b100010, 6'b000000, 6'b000010};

    initial begin
        sig_t o, rv;
        logic [17:0] ov, rvv;
        logic [5:0] op, fn;
        int fs, ms;

        reset        = 1'b0;
        ctl.Opcode   = 6'b0;
        ctl.Funct    = 6'b0;
        ctl.Zero     = 1'b0;
        ctl.MemReady = 1'b0;
        rv           = '0;
        rv.alu       = 4'b0011;
        rvv          = rv;

        @(posedge clk);
        #1 o = observe(); ov = o;
        check_val("reset_init", 32'(ov), 32'(rvv));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);

        // directed cases
        run_instr(6'b000000, 6'b100000, 0, 0, -1);   // ADD
        run_instr(6'b100011, 6'b000000, 0, 3, -1);   // LW, 3 stall cycles
        run_instr(6'b000100, 6'b000000, 0, 0, 1);    // BEQ taken
        run_instr(6'b000101, 6'b000000, 0, 0, 1);    // BNE not taken
        run_instr(6'b001111, 6'b000000, 0, 0, -1);   // LUI
        run_instr(6'b111111, 6'b000000, 0, 0, -1);   // undefined opcode
        run_instr(6'b000000, 6'b111111, 0, 0, -1);   // undefined funct
        run_instr(6'b101011, 6'b000000, 2, 2, -1);   // SW with stalls

        // reset while LW waits in MEM_RD
        cur_op = 6'b100011;
        cur_fn = 6'b000000;
        build(cur_op, cur_fn, 0, 3, -1);
        run_trace(5);
        do_reset();
        run_instr(6'b000010, 6'b000000, 0, 0, -1);   // J right after reset

        // randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_pool[$urandom_range(0, 8)];
            fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 6)];
            fs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            ms = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_instr(op, fn, fs, ms, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
